fft_stage_sched: RTL and testbench

Sequencer for an in-place radix-2 decimation-in-time FFT built around one shared pipelined complex multiplier. It has two jobs:
- walk all log2(N) stages and N/2 butterflies per stage, generating dual-port data RAM read/write addresses and twiddle ROM addresses;
- issue operands to the multiplier and align write-back with its fixed latency.

It sits between the control/host logic (start/done) and the butterfly datapath (data RAM, twiddle ROM, complex multiplier, add/sub). The data RAM is pre-loaded in bit-reversed order; this block does no reordering.

---
 rtl/fft_stage_sched.sv | 164 ++++++++++++++++
 tb/tb_fft_stage_sched.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fft_stage_sched.sv
// Address and operand sequencer for an in-place radix-2 DIT FFT sharing one pipelined
// complex multiplier; write-back is aligned to the multiplier latency via a delay line.
//
// state | meaning
// IDLE  | waiting for start_i; done_o pulses on the cycle after the final write-back
// RUN   | one butterfly read issued per cycle for the current stage
// DRAIN | no reads; waits MULT_LAT+1 cycles so stage s writes land before stage s+1 reads
module fft_stage_sched #(
    parameter int LOG2N    = 10,
    parameter int MULT_LAT = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       stage_o,
    output logic             rd_en_o,
    output logic [LOG2N-1:0] rd_addr_a_o,
    output logic [LOG2N-1:0] rd_addr_b_o,
    output logic [LOG2N-2:0] tw_addr_o,
    output logic             mult_valid_o,
    output logic             wr_en_o,
    output logic [LOG2N-1:0] wr_addr_a_o,
    output logic [LOG2N-1:0] wr_addr_b_o
);

    localparam int KW = LOG2N - 1;
    localparam int CW = $clog2(MULT_LAT + 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q;
    logic [KW-1:0]   k_q;
    logic [CW-1:0]   drain_cnt_q;

    logic [4:0]       iss_s;
    logic [KW-1:0]    iss_k;
    logic [LOG2N-1:0] kx;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    logic [LOG2N-1:0] iss_a;
    logic [LOG2N-1:0] iss_b;
    logic [LOG2N-1:0] tw_full;
    logic [KW-1:0]    iss_tw;

    // Addresses of the butterfly that the FSM issues on the coming edge.
    always_comb begin
        iss_s = {1'b0, stage_o};
        iss_k = k_q + 1'b1;
        case (state_q)
            IDLE: begin
                iss_s = '0;
                iss_k = '0;
            end
            DRAIN: begin
                iss_s = {1'b0, stage_o} + 5'd1;
                iss_k = '0;
            end
            default: ;
        endcase
        kx      = LOG2N'(iss_k);
        half    = LOG2N'(1) << iss_s;
        pos     = kx & (half - 1'b1);
        grp     = kx >> iss_s;
        iss_a   = (grp << (iss_s + 5'd1)) | pos;
        iss_b   = iss_a + half;
        tw_full = pos << (5'(LOG2N - 1) - iss_s);
        iss_tw  = tw_full[KW-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            k_q         <= '0;
            drain_cnt_q <= '0;
            stage_o     <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            rd_en_o     <= 1'b0;
            rd_addr_a_o <= '0;
            rd_addr_b_o <= '0;
            tw_addr_o   <= '0;
        end else begin
            done_o  <= 1'b0;
            rd_en_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= RUN;
                        busy_o      <= 1'b1;
                        stage_o     <= '0;
                        k_q         <= '0;
                        rd_en_o     <= 1'b1;
                        rd_addr_a_o <= iss_a;
                        rd_addr_b_o <= iss_b;
                        tw_addr_o   <= iss_tw;
                    end
                end
                RUN: begin
                    if (&k_q) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= CW'(MULT_LAT + 1);
                    end else begin
                        k_q         <= k_q + 1'b1;
                        rd_en_o     <= 1'b1;
                        rd_addr_a_o <= iss_a;
                        rd_addr_b_o <= iss_b;
                        tw_addr_o   <= iss_tw;
                    end
                end
                DRAIN: begin
                    drain_cnt_q <= drain_cnt_q - 1'b1;
                    if (drain_cnt_q == CW'(1)) begin
                        if (stage_o == 4'(LOG2N - 1)) begin
                            state_q <= IDLE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else begin
                            state_q     <= RUN;
                            stage_o     <= stage_o + 1'b1;
                            k_q         <= '0;
                            rd_en_o     <= 1'b1;
                            rd_addr_a_o <= iss_a;
                            rd_addr_b_o <= iss_b;
                            tw_addr_o   <= iss_tw;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tap 0 is the RAM/ROM read latency (multiplier issue); the last tap is multiplier output.
    logic [MULT_LAT:0] wb_vld_q;
    logic [LOG2N-1:0]  wb_a_q [MULT_LAT+1];
    logic [LOG2N-1:0]  wb_b_q [MULT_LAT+1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_vld_q <= '0;
            for (int i = 0; i <= MULT_LAT; i++) begin
                wb_a_q[i] <= '0;
                wb_b_q[i] <= '0;
            end
        end else begin
            wb_vld_q  <= {wb_vld_q[MULT_LAT-1:0], rd_en_o};
            wb_a_q[0] <= rd_addr_a_o;
            wb_b_q[0] <= rd_addr_b_o;
            for (int i = 1; i <= MULT_LAT; i++) begin
                wb_a_q[i] <= wb_a_q[i-1];
                wb_b_q[i] <= wb_b_q[i-1];
            end
        end
    end

    assign mult_valid_o = wb_vld_q[0];
    assign wr_en_o      = wb_vld_q[MULT_LAT];
    assign wr_addr_a_o  = wb_a_q[MULT_LAT];
    assign wr_addr_b_o  = wb_b_q[MULT_LAT];

endmodule

// File: tb/tb_fft_stage_sched.sv
// Directed bench for fft_stage_sched at LOG2N=3, MULT_LAT=5 (P = 10, done at cycle 31).
module tb_fft_stage_sched;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       busy_o, done_o, rd_en_o, mult_valid_o, wr_en_o;
    logic [3:0] stage_o;
    logic [2:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
    logic [1:0] tw_addr_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Hand-derived butterfly sequence, stages 0..2, four butterflies each.
    int exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    fft_stage_sched #(.LOG2N(3), .MULT_LAT(5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .stage_o      (stage_o),
        .rd_en_o      (rd_en_o),
        .rd_addr_a_o  (rd_addr_a_o),
        .rd_addr_b_o  (rd_addr_b_o),
        .tw_addr_o    (tw_addr_o),
        .mult_valid_o (mult_valid_o),
        .wr_en_o      (wr_en_o),
        .wr_addr_a_o  (wr_addr_a_o),
        .wr_addr_b_o  (wr_addr_b_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, c, got, exp);
        end
    endtask

    // Read windows for P=10: cycles 1-4, 11-14, 21-24.
    function automatic bit in_rd(input int c);
        return (c >= 1 && c <= 4) || (c >= 11 && c <= 14) || (c >= 21 && c <= 24);
    endfunction

    function automatic int rd_idx(input int c);
        return ((c - 1) / 10) * 4 + (c - 1) % 10;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"},  0, int'(busy_o), 0);
        chk({tag, "_done"},  0, int'(done_o), 0);
        chk({tag, "_stage"}, 0, int'(stage_o), 0);
        chk({tag, "_rd"},    0, int'(rd_en_o), 0);
        chk({tag, "_ra"},    0, int'(rd_addr_a_o), 0);
        chk({tag, "_rb"},    0, int'(rd_addr_b_o), 0);
        chk({tag, "_tw"},    0, int'(tw_addr_o), 0);
        chk({tag, "_mv"},    0, int'(mult_valid_o), 0);
        chk({tag, "_wr"},    0, int'(wr_en_o), 0);
        chk({tag, "_wa"},    0, int'(wr_addr_a_o), 0);
        chk({tag, "_wb"},    0, int'(wr_addr_b_o), 0);
    endtask

    // Caller sets start_i before the cycle-0 edge; checks cycles first..last of that run.
    task automatic run_cycles(input int first, input int last, input bit keep_start);
        for (int c = first; c <= last; c++) begin
            tick();
            if (!keep_start) start_i = (c == 10);
            chk("rd_en",  c, int'(rd_en_o),      int'(in_rd(c)));
            chk("mvalid", c, int'(mult_valid_o), int'(in_rd(c - 1)));
            chk("wr_en",  c, int'(wr_en_o),      int'(in_rd(c - 6)));
            chk("busy",   c, int'(busy_o),       int'(c >= 1 && c <= 30));
            chk("done",   c, int'(done_o),       int'(c == 31));
            if (in_rd(c)) begin
                chk("rd_a",  c, int'(rd_addr_a_o), exp_a[rd_idx(c)]);
                chk("rd_b",  c, int'(rd_addr_b_o), exp_b[rd_idx(c)]);
                chk("tw",    c, int'(tw_addr_o),   exp_tw[rd_idx(c)]);
                chk("stage", c, int'(stage_o),     (c - 1) / 10);
            end
            if (in_rd(c - 6)) begin
                chk("wr_a", c, int'(wr_addr_a_o), exp_a[rd_idx(c - 6)]);
                chk("wr_b", c, int'(wr_addr_b_o), exp_b[rd_idx(c - 6)]);
            end
        end
    endtask

    initial begin
        // Reset values, then idle with no start.
        #2;
        check_idle_zero("rst");
        tick();
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_rd",   i, int'(rd_en_o), 0);
            chk("idle_busy", i, int'(busy_o),  0);
            chk("idle_wr",   i, int'(wr_en_o), 0);
        end

        // Run 1: single start pulse, start_i re-pulsed at cycle 10 (ignored).
        start_i = 1'b1;
        run_cycles(1, 31, 1'b0);

        // Run 2 starts in run 1's done cycle; start_i stays high throughout.
        start_i = 1'b1;
        run_cycles(1, 31, 1'b1);
        // Run 3 begins at run 2 cycle 32; reset it at cycle 13.
        run_cycles(1, 13, 1'b1);
        start_i = 1'b0;
        rst_i   = 1'b1;
        #1;
        check_idle_zero("midrst");
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("post_rst_wr",   i, int'(wr_en_o), 0);
            chk("post_rst_done", i, int'(done_o),  0);
            chk("post_rst_rd",   i, int'(rd_en_o), 0);
        end

        // Run 4: clean run after reset.
        start_i = 1'b1;
        run_cycles(1, 31, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
